// File: rtl/stack_calc_param.sv
// Parametrised stack calculator: single-cycle command engine over a WIDTH x DEPTH
// register stack, with per-command accept/reject pulses and arithmetic overflow.
module stack_calc_param #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       op,
    input  logic             apply,
    output logic [WIDTH-1:0] tail,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             valid,
    output logic             err,
    output logic             ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MUL  = 3'b011,
        OP_POP  = 3'b100,
        OP_PUSH = 3'b101,
        OP_DUP  = 3'b110,
        OP_SWAP = 3'b111
    } op_e;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [CW-1:0]      count_q, count_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;

    logic [AW-1:0]      top_idx, below_idx, push_idx;
    logic [WIDTH-1:0]   a, b;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic               has_one, has_two, has_room;
    op_e                op_s;

    assign op_s      = op_e'(op);
    assign top_idx   = AW'(count_q - CW'(1));
    assign below_idx = AW'(count_q - CW'(2));
    assign push_idx  = AW'(count_q);
    assign a         = mem_q[top_idx];
    assign b         = mem_q[below_idx];

    // Carry and borrow fall out of the extra MSB of the widened sum/difference.
    assign sum  = {1'b0, b} + {1'b0, a};
    assign diff = {1'b0, b} - {1'b0, a};
    assign prod = {{WIDTH{1'b0}}, b} * {{WIDTH{1'b0}}, a};

    assign has_one  = (count_q != '0);
    assign has_two  = (count_q >= CW'(2));
    assign has_room = (count_q < CW'(DEPTH));

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path can infer a latch.
        mem_d   = mem_q;
        count_d = count_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        ovf_d   = 1'b0;
        if (apply) begin
            unique case (op_s)
                OP_NOP: ;
                OP_ADD, OP_SUB, OP_MUL: begin
                    if (has_two) begin
                        valid_d = 1'b1;
                        count_d = count_q - CW'(1);
                        if (op_s == OP_ADD) begin
                            mem_d[below_idx] = sum[WIDTH-1:0];
                            ovf_d            = sum[WIDTH];
                        end else if (op_s == OP_SUB) begin
                            mem_d[below_idx] = diff[WIDTH-1:0];
                            ovf_d            = diff[WIDTH];
                        end else begin
                            mem_d[below_idx] = prod[WIDTH-1:0];
                            ovf_d            = |prod[2*WIDTH-1:WIDTH];
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_POP: begin
                    if (has_one) begin
                        valid_d = 1'b1;
                        count_d = count_q - CW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_PUSH: begin
                    if (has_room) begin
                        valid_d         = 1'b1;
                        count_d         = count_q + CW'(1);
                        mem_d[push_idx] = in;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_DUP: begin
                    if (has_one && has_room) begin
                        valid_d         = 1'b1;
                        count_d         = count_q + CW'(1);
                        mem_d[push_idx] = a;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_SWAP: begin
                    if (has_two) begin
                        valid_d          = 1'b1;
                        mem_d[top_idx]   = b;
                        mem_d[below_idx] = a;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: storage is cleared on reset because the stack contents are architecturally visible state.
            mem_q   <= '{default: '0};
            count_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            mem_q   <= mem_d;
            count_q <= count_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tail  = has_one ? a : '0;
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign valid = valid_q;
    assign err   = err_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_stack_calc_param.sv
// Scoreboard bench for stack_calc_param: directed commands queue hand-computed results,
// a negedge monitor pops and compares them in the cycle the DUT presents them.
module tb_stack_calc_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] ADD  = 3'b001;
    localparam logic [2:0] SUB  = 3'b010;
    localparam logic [2:0] MUL  = 3'b011;
    localparam logic [2:0] POP  = 3'b100;
    localparam logic [2:0] PUSH = 3'b101;
    localparam logic [2:0] DUP  = 3'b110;
    localparam logic [2:0] SWAP = 3'b111;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] in_d = '0;
    logic [2:0]       op = 3'b000;
    logic             apply = 1'b0;
    logic [WIDTH-1:0] tail;
    logic             empty, full, valid, err, ovf;
    logic [CW-1:0]    count;

    stack_calc_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in_d),
        .op    (op),
        .apply (apply),
        .tail  (tail),
        .empty (empty),
        .full  (full),
        .count (count),
        .valid (valid),
        .err   (err),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        int               id;
        logic [WIDTH-1:0] tail;
        logic [CW-1:0]    count;
        logic             valid;
        logic             err;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cmd    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Expectation for a command that takes effect at the next rising edge.
    task automatic expect_next(input logic [WIDTH-1:0] t, input int c,
                               input logic v, input logic e, input logic ov);
        exp_t x;
        n_cmd++;
        x.cyc   = cyc + 1;
        x.id    = n_cmd;
        x.tail  = t;
        x.count = CW'(c);
        x.valid = v;
        x.err   = e;
        x.ovf   = ov;
        sb.push_back(x);
    endtask

    task automatic cmd(input logic [2:0] o, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] t, input int c,
                       input logic v, input logic e, input logic ov);
        @(posedge clk);
        #2;
        apply = 1'b1;
        op    = o;
        in_d  = d;
        expect_next(t, c, v, e, ov);
    endtask

    task automatic ok(input logic [2:0] o, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] t, input int c, input logic ov);
        cmd(o, d, t, c, 1'b1, 1'b0, ov);
    endtask

    task automatic bad(input logic [2:0] o, input logic [WIDTH-1:0] t, input int c);
        cmd(o, 8'hAA, t, c, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        apply = 1'b0;
        op    = NOP;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tail"},  32'(tail),  32'h0);
        check({tag, "_count"}, 32'(count), 32'h0);
        check({tag, "_empty"}, 32'(empty), 32'h1);
        check({tag, "_full"},  32'(full),  32'h0);
        check({tag, "_valid"}, 32'(valid), 32'h0);
        check({tag, "_err"},   32'(err),   32'h0);
        check({tag, "_ovf"},   32'(ovf),   32'h0);
    endtask

    // Monitor: compares the queued result scheduled for this cycle; flags stray pulses.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missed_result#%0d: got none expected at cycle %0d", e.id, e.cyc);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check($sformatf("tail#%0d", e.id),  32'(tail),  32'(e.tail));
                check($sformatf("count#%0d", e.id), 32'(count), 32'(e.count));
                check($sformatf("valid#%0d", e.id), 32'(valid), 32'(e.valid));
                check($sformatf("err#%0d", e.id),   32'(err),   32'(e.err));
                check($sformatf("ovf#%0d", e.id),   32'(ovf),   32'(e.ovf));
                check($sformatf("empty#%0d", e.id), 32'(empty), 32'(e.count == 0));
                check($sformatf("full#%0d", e.id),  32'(full),  32'(e.count == CW'(DEPTH)));
            end else if (valid || err) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none at cycle %0d",
                         valid, err, cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of test expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        // Power-on reset.
        #13;
        check_reset_outputs("por");
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Basic push / multiply / pop.
        ok(PUSH, 8'h02, 8'h02, 1, 1'b0);
        ok(PUSH, 8'h04, 8'h04, 2, 1'b0);
        ok(PUSH, 8'h01, 8'h01, 3, 1'b0);
        ok(MUL,  8'h00, 8'h04, 2, 1'b0);
        ok(POP,  8'h00, 8'h02, 1, 1'b0);

        // Subtract with borrow, add without carry.
        ok(PUSH, 8'h06, 8'h06, 2, 1'b0);
        ok(PUSH, 8'h25, 8'h25, 3, 1'b0);
        ok(SUB,  8'h00, 8'hE1, 2, 1'b1);
        ok(ADD,  8'h00, 8'hE3, 1, 1'b0);

        // Multiply and add overflow wrapping to zero.
        ok(PUSH, 8'h80, 8'h80, 2, 1'b0);
        ok(PUSH, 8'h02, 8'h02, 3, 1'b0);
        ok(MUL,  8'h00, 8'h00, 2, 1'b1);
        ok(PUSH, 8'hFF, 8'hFF, 3, 1'b0);
        ok(PUSH, 8'h01, 8'h01, 4, 1'b0);
        ok(ADD,  8'h00, 8'h00, 3, 1'b1);

        // Drain to empty; NOP and POP on empty.
        ok(POP, 8'h00, 8'h00, 2, 1'b0);
        ok(POP, 8'h00, 8'hE3, 1, 1'b0);
        ok(POP, 8'h00, 8'h00, 0, 1'b0);
        cmd(NOP, 8'h33, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        bad(POP, 8'h00, 0);

        // Single entry: SWAP rejected, DUP then SWAP accepted.
        ok(PUSH, 8'h07, 8'h07, 1, 1'b0);
        bad(SWAP, 8'h07, 1);
        bad(ADD,  8'h07, 1);
        ok(DUP,  8'h00, 8'h07, 2, 1'b0);
        ok(SWAP, 8'h00, 8'h07, 2, 1'b0);
        ok(POP,  8'h00, 8'h07, 1, 1'b0);
        ok(POP,  8'h00, 8'h00, 0, 1'b0);
        bad(DUP, 8'h00, 0);

        // Fill to DEPTH, then overflow attempts.
        for (int i = 1; i <= DEPTH; i++) ok(PUSH, 8'(i), 8'(i), i, 1'b0);
        bad(PUSH, 8'h08, DEPTH);
        bad(DUP,  8'h08, DEPTH);
        ok(POP,  8'hAA, 8'h07, 7, 1'b0);
        ok(SWAP, 8'h00, 8'h06, 7, 1'b0);
        ok(SUB,  8'h00, 8'h01, 6, 1'b0);
        ok(ADD,  8'h00, 8'h06, 5, 1'b0);

        // Three pushes, then asynchronous reset between edges.
        ok(PUSH, 8'h11, 8'h11, 6, 1'b0);
        ok(PUSH, 8'h22, 8'h22, 7, 1'b0);
        ok(PUSH, 8'h33, 8'h33, 8, 1'b0);
        idle();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst   = 1'b0;
        apply = 1'b1;
        op    = PUSH;
        in_d  = 8'h5A;
        #1;
        check_reset_outputs("async_rst");
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_count", 32'(count), 32'h0);
        check("rst_hold_tail",  32'(tail),  32'h0);
        check("rst_hold_valid", 32'(valid), 32'h0);
        #1;
        rst = 1'b1;
        expect_next(8'h5A, 1, 1'b1, 1'b0, 1'b0);

        // Equal-operand subtract and multiply by zero after reset.
        ok(PUSH, 8'h05, 8'h05, 2, 1'b0);
        ok(PUSH, 8'h05, 8'h05, 3, 1'b0);
        ok(SUB,  8'h00, 8'h00, 2, 1'b0);
        ok(MUL,  8'h00, 8'h00, 1, 1'b0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_calc_param.md
Name: stack_calc_param

Overview:
- Parametrised successor of the 8-bit stack calculator (`main`).
- Generalised in data width and stack depth.
- Adds DUP/SWAP/SUB/MUL, full flag, occupancy count, per-op error and arithmetic-overflow reporting.
- Single-cycle command engine driven by an op/apply strobe; top of stack is always visible on `tail`.

Parameters:
- WIDTH, 8, data width of operands, stack entries and `tail`.
- DEPTH, 8, maximum number of stack entries (≥2).
- CW (localparam), $clog2(DEPTH+1), width of `count`.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- in  input  WIDTH  operand for PUSH.
- op  input  3  command code.
- apply  input  1  command strobe, sampled on rising clk.
- tail  output  WIDTH  current top-of-stack value; 0 when empty.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  CW  number of valid entries.
- valid  output  1  one-cycle pulse: previous command accepted.
- err  output  1  one-cycle pulse: previous command rejected.
- ovf  output  1  one-cycle pulse with valid: arithmetic result lost bits.

Behaviour:
- Reset (rst=0, asynchronous): count=0, all storage=0, tail=0, empty=1, full=0, valid=0, err=0, ovf=0. `apply` has no effect while rst=0.
- Reset deassertion is synchronised by the user. The first rising edge with rst=1 processes `apply` normally.
- Reset during any op: the stack is cleared immediately, and no partial update survives.
- Commands execute on the rising edge when apply=1. All outputs are registered, so results are visible the cycle after the edge. Back-to-back commands are allowed every cycle.
- Op codes (a = top, b = entry below top):
  - 000 NOP: no change, no valid/err pulse.
  - 001 ADD: pop a, b; push b+a.
  - 010 SUB: pop a, b; push b−a.
  - 011 MUL: pop a, b; push low WIDTH bits of b*a.
  - 100 POP: remove top.
  - 101 PUSH: push `in`.
  - 110 DUP: push copy of a.
  - 111 SWAP: exchange a and b.
- Preconditions (count values):
  - PUSH: count < DEPTH.
  - DUP: 1 ≤ count < DEPTH.
  - POP: count ≥ 1.
  - ADD/SUB/MUL/SWAP: count ≥ 2.
- Precondition violated: stack and count unchanged, err=1, valid=0 for one cycle.
- Accepted op: valid=1, err=0 for one cycle.
- Cycles with apply=0 or NOP: valid=err=ovf=0.
- Count changes:
  - PUSH/DUP: +1.
  - POP/ADD/SUB/MUL: −1.
  - SWAP: unchanged.
- Arithmetic is modulo 2^WIDTH.
- ovf=1 (only alongside valid) when:
  - ADD: carry out of bit WIDTH−1.
  - SUB: borrow (b < a, unsigned).
  - MUL: any nonzero bit in product[2*WIDTH−1:WIDTH].
  - ovf=0 for all other ops.
- Flag behaviour:
  - `tail` always equals storage[count−1], or 0 when count=0.
  - empty and full follow count combinationally from the registered count.
- Entries above count are don't-care internally but never appear on `tail`.
- Data `in` is ignored for every op except PUSH.
- Undefined op/apply (X) is not required to be handled.

Test Plan:
- Reset, then PUSH 2, PUSH 4, PUSH 1 → after third, tail=1, count=3, valid pulses each cycle. MUL → tail=4, count=2, ovf=0. POP → tail=2, count=1.
- From count=1 (tail=2): PUSH 6, PUSH 0x25, SUB → tail=0xE1, count=2, ovf=1 (6 < 0x25). ADD with tail=0xE1 over 2 → tail=0xE3, ovf=0.
- PUSH 0x80, PUSH 0x02, MUL → tail=0x00, ovf=1. PUSH 0xFF, PUSH 0x01, ADD → tail=0x00, ovf=1.
- Empty stack: POP → err=1, valid=0, count=0, tail=0. Single entry 7: SWAP → err=1, tail=7. DUP → tail=7, count=2. SWAP → valid=1, tail=7.
- Fill DEPTH=8 pushes (values 1..8) → full=1, tail=8. 9th PUSH 9 → err=1, tail=8, count=8. DUP → err=1. POP → full=0, tail=7.
- After 3 pushes, drive rst=0 mid-cycle between edges → outputs go to reset values immediately with no clock. Hold apply=1/PUSH during reset → count stays 0. First edge after rst=1 pushes `in`, count=1.
